load_store_unit: RTL and testbench

- Data-memory stage downstream of the single-cycle execute datapath; services RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Multi-cycle: accepts one request via valid/ready, models a configurable wait-state latency, then returns a one-cycle response.
- The core stalls on req_ready=0 and writes rdata to the register file on resp_valid.
- Backing store is an internal word array named memory, preloadable by benches with $readmemh.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I data-memory stage (LB/LH/LW/LBU/LHU/SB/SH/SW). It accepts
//            one request through a valid/ready handshake, waits WAIT_CYCLES
//            wait states, performs the access on the internal word array
//            'memory', and then returns a one-cycle response.
// Options  : MISALIGNED_TRAP_EN - when defined, misaligned halfword and word
//            accesses are rejected with err=1. When undefined, the low
//            address bits are forced to alignment.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         c_AW   = $clog2(MEM_WORDS);
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Backing store. It has no reset, so its contents survive a reset.
    logic [31:0] memory [MEM_WORDS];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic            r_write;
    logic [2:0]      r_funct3;
    logic [c_AW+1:0] r_addr;
    logic [31:0]     r_wdata;
    logic            r_resp_valid;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_accept;
    logic            w_access;
    logic [c_AW-1:0] w_index;
    logic [1:0]      w_off;
    logic            w_illegal;
    logic            w_misaligned;
    logic            w_reject;
    logic [31:0]     w_word;
    logic [31:0]     w_shifted;
    logic [31:0]     w_load;
    logic [3:0]      w_bmask;
    logic [31:0]     w_lane_data;
    logic [31:0]     w_merged;
    logic            w_unused_addr;

    // Upper address bits are ignored, so addresses wrap modulo the memory size.
    assign w_unused_addr = &{1'b0, addr[31:c_AW+2]};

    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;
    assign w_access   = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_index    = r_addr[c_AW+1:2];
    assign w_word     = memory[w_index];
    assign resp_valid = r_resp_valid;
    assign rdata      = r_rdata;
    assign err        = r_err;

    // Decode legality and the effective lane offset of the latched request.
    always_comb begin
        w_off        = r_addr[1:0];
        w_misaligned = 1'b0;
        if (r_write)
            w_illegal = (r_funct3 == 3'b011) || r_funct3[2];
        else
            w_illegal = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) ||
                        (r_funct3 == 3'b111);
`ifdef MISALIGNED_TRAP_EN
        if (r_funct3[1:0] == 2'b01)
            w_misaligned = r_addr[0];
        else if (r_funct3[1:0] == 2'b10)
            w_misaligned = (r_addr[1:0] != 2'b00);
`else
        if (r_funct3[1:0] == 2'b01)
            w_off = {r_addr[1], 1'b0};
        else if (r_funct3[1:0] == 2'b10)
            w_off = 2'b00;
`endif
        w_reject = w_illegal || w_misaligned;
    end

    // Select the addressed byte or halfword lane and extend it to 32 bits.
    always_comb begin
        w_shifted = w_word >> {w_off, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'h0, w_shifted[7:0]};
            3'b101:  w_load = {16'h0, w_shifted[15:0]};
            default: w_load = 32'h0;
        endcase
    end

    // Merge store data into the addressed lanes and keep the other bytes.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_bmask = 4'b0001 << w_off;
            2'b01:   w_bmask = 4'b0011 << w_off;
            default: w_bmask = 4'b1111;
        endcase
        w_lane_data = r_wdata << {w_off, 3'b000};
        w_merged    = w_word;
        for (int b = 0; b < 4; b++) begin
            if (w_bmask[b])
                w_merged[8*b +: 8] = w_lane_data[8*b +: 8];
        end
    end

    // Next-state logic for the IDLE -> BUSY -> DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Request latch, wait counter, and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                r_write  <= req_write;
                r_funct3 <= funct3;
                r_addr   <= addr[c_AW+1:0];
                r_wdata  <= wdata;
                r_cnt    <= c_WAIT;
            end else if (r_state == S_BUSY) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_resp_valid <= 1'b1;
                    r_err        <= w_reject;
                    r_rdata      <= (r_write || w_reject) ? 32'h0 : w_load;
                end
            end
        end
    end

    // Stores commit on the access edge so an immediately following load sees them.
    always_ff @(posedge clk) begin
        if (!reset && w_access && r_write && !w_reject)
            memory[w_index] <= w_merged;
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit (WAIT_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;

    int n_err;
    int n_chk;

    load_store_unit #(
        .MEM_WORDS   (256),
        .WAIT_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge and return the response fields.
    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_write = w;
        funct3    = f;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", {31'h0, resp_valid}, 32'h1);
        rd = rdata;
        e  = err;
    endtask

    logic [31:0] rd;
    logic        e;
    int          seen;

    initial begin
        n_err     = 0;
        n_chk     = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp",  {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err",   {31'h0, err}, 32'h0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
        @(negedge clk);

        // Preload word 0 and check store response
        do_req(1'b1, 3'b010, 32'h0, 32'h8000_7F81, rd, e);
        chk("sw0_rdata", rd, 32'h0);
        chk("sw0_err", {31'h0, e}, 32'h0);

        // Load extension
        do_req(1'b0, 3'b000, 32'h0, 32'h0, rd, e);
        chk("lb0", rd, 32'hFFFF_FF81);
        chk("lb0_err", {31'h0, e}, 32'h0);
        do_req(1'b0, 3'b100, 32'h0, 32'h0, rd, e);
        chk("lbu0", rd, 32'h0000_0081);
        chk("lbu0_err", {31'h0, e}, 32'h0);
        do_req(1'b0, 3'b000, 32'h1, 32'h0, rd, e);
        chk("lb1", rd, 32'h0000_007F);
        chk("lb1_err", {31'h0, e}, 32'h0);
        do_req(1'b0, 3'b001, 32'h2, 32'h0, rd, e);
        chk("lh2", rd, 32'hFFFF_8000);
        do_req(1'b0, 3'b101, 32'h2, 32'h0, rd, e);
        chk("lhu2", rd, 32'h0000_8000);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, e);
        chk("lw0", rd, 32'h8000_7F81);
        // Upper address bits ignored: 0x400 wraps to word 0
        do_req(1'b0, 3'b010, 32'h0000_0400, 32'h0, rd, e);
        chk("lw_wrap", rd, 32'h8000_7F81);

        // Partial stores
        do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, rd, e);
        do_req(1'b1, 3'b000, 32'h11, 32'hFFFF_FFAA, rd, e);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        chk("sb_merge", rd, 32'h1122_AA44);
        do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, rd, e);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_BEEF, rd, e);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, e);
        chk("sh_merge", rd, 32'hBEEF_3344);

        // Misaligned word load
        do_req(1'b0, 3'b010, 32'h2, 32'h0, rd, e);
`ifdef MISALIGNED_TRAP_EN
        chk("lw_mis_rdata", rd, 32'h0);
        chk("lw_mis_err", {31'h0, e}, 32'h1);
`else
        chk("lw_mis_rdata", rd, 32'h8000_7F81);
        chk("lw_mis_err", {31'h0, e}, 32'h0);
`endif

        // Illegal funct3
        do_req(1'b0, 3'b011, 32'h0, 32'h0, rd, e);
        chk("ill_ld_err", {31'h0, e}, 32'h1);
        chk("ill_ld_rdata", rd, 32'h0);
        do_req(1'b1, 3'b100, 32'h0, 32'h1234_5678, rd, e);
        chk("ill_st_err", {31'h0, e}, 32'h1);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, e);
        chk("ill_st_nowrite", rd, 32'h8000_7F81);

        // Latency with req_valid held high (already at a negedge in IDLE)
        @(negedge clk);
        chk("lat_ready0", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_write = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h0;
        @(posedge clk);
        @(negedge clk);
        chk("lat_e0_ready", {31'h0, req_ready}, 32'h0);
        chk("lat_e0_resp", {31'h0, resp_valid}, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("lat_e%0d_resp", k), {31'h0, resp_valid}, (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("lat_e%0d_ready", k), {31'h0, req_ready}, (k == 5) ? 32'h1 : 32'h0);
            if (k == 4) chk("lat_rdata", rdata, 32'h8000_7F81);
        end
        req_valid = 1'b0;
        @(negedge clk);

        // Reset abort during BUSY
        do_req(1'b1, 3'b010, 32'h20, 32'h5566_7788, rd, e);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h20;
        wdata     = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("abort_no_resp", seen, 32'h0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, e);
        chk("abort_mem", rd, 32'h5566_7788);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
